// File: rtl/deal_sequencer.sv
// Baccarat round sequencer: issues card-register load strobes, applies the third-card
// drawing rules and lights the winner. Optional auto-restart when AUTO_RESTART_EN is defined.
module deal_sequencer #(
  parameter int HOLD_CYCLES = 8
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       new_round,
  output logic [3:0] dbg_state
);

  typedef enum logic [3:0] {
    S_RST, S_P1, S_D1, S_P2, S_D2, S_EVAL, S_P3, S_BDEC, S_D3, S_DONE
`ifdef AUTO_RESTART_EN
    , S_CLR
`endif
  } state_t;

  // One-hot strobe vector: bit order P1, D1, P2, D2, P3, D3.
  localparam logic [5:0] LD_P1 = 6'b000001;
  localparam logic [5:0] LD_D1 = 6'b000010;
  localparam logic [5:0] LD_P2 = 6'b000100;
  localparam logic [5:0] LD_D2 = 6'b001000;
  localparam logic [5:0] LD_P3 = 6'b010000;
  localparam logic [5:0] LD_D3 = 6'b100000;

  state_t     state_q;
  logic [5:0] load_q;
  logic [3:0] third_val;
  logic       dealer_draws;
  logic       natural;
  logic       in_done;

  // Tens and face cards count zero toward the hand.
  assign third_val = (pcard3 >= 4'd10) ? 4'd0 : pcard3;
  assign natural   = (pscore >= 4'd8) || (dscore >= 4'd8);

  always_comb begin
    dealer_draws = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: dealer_draws = 1'b1;
      4'd3:             dealer_draws = (third_val != 4'd8);
      4'd4:             dealer_draws = (third_val >= 4'd2) && (third_val <= 4'd7);
      4'd5:             dealer_draws = (third_val >= 4'd4) && (third_val <= 4'd7);
      4'd6:             dealer_draws = (third_val >= 4'd6) && (third_val <= 4'd7);
      default:          dealer_draws = 1'b0;
    endcase
  end

`ifdef AUTO_RESTART_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  logic [7:0] hold_cnt_q;
  logic       new_round_q;
`else
  logic unused_hold;
  assign unused_hold = ^HOLD_CYCLES;
`endif

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_q     <= S_RST;
      load_q      <= '0;
`ifdef AUTO_RESTART_EN
      hold_cnt_q  <= '0;
      new_round_q <= 1'b0;
`endif
    end else begin
      load_q <= '0;
`ifdef AUTO_RESTART_EN
      new_round_q <= 1'b0;
`endif
      case (state_q)
        S_RST:  begin state_q <= S_P1; load_q <= LD_P1; end
        S_P1:   begin state_q <= S_D1; load_q <= LD_D1; end
        S_D1:   begin state_q <= S_P2; load_q <= LD_P2; end
        S_P2:   begin state_q <= S_D2; load_q <= LD_D2; end
        S_D2:   state_q <= S_EVAL;
        S_EVAL: begin
          if (natural) begin
            state_q <= S_DONE;
          end else if (pscore <= 4'd5) begin
            state_q <= S_P3;
            load_q  <= LD_P3;
          end else if (dscore <= 4'd5) begin
            state_q <= S_D3;
            load_q  <= LD_D3;
          end else begin
            state_q <= S_DONE;
          end
        end
        S_P3:   state_q <= S_BDEC;
        // pcard3 is valid here because P3's strobe was captured on the edge leaving P3.
        S_BDEC: begin
          if (dealer_draws) begin
            state_q <= S_D3;
            load_q  <= LD_D3;
          end else begin
            state_q <= S_DONE;
          end
        end
        S_D3:   state_q <= S_DONE;
        S_DONE: begin
`ifdef AUTO_RESTART_EN
          if (hold_cnt_q == HOLD_LAST) begin
            state_q     <= S_CLR;
            new_round_q <= 1'b1;
            hold_cnt_q  <= '0;
          end else begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end
`else
          state_q <= S_DONE;
`endif
        end
`ifdef AUTO_RESTART_EN
        S_CLR:  begin state_q <= S_P1; load_q <= LD_P1; end
`endif
        default: state_q <= S_RST;
      endcase
    end
  end

  assign load_pcard1 = load_q[0];
  assign load_dcard1 = load_q[1];
  assign load_pcard2 = load_q[2];
  assign load_dcard2 = load_q[3];
  assign load_pcard3 = load_q[4];
  assign load_dcard3 = load_q[5];

  // Lights follow the live scores so the last dealer card is included in DONE.
  assign in_done          = (state_q == S_DONE);
  assign player_win_light = in_done && (pscore >= dscore);
  assign dealer_win_light = in_done && (dscore >= pscore);

`ifdef AUTO_RESTART_EN
  assign new_round = new_round_q;
`else
  assign new_round = 1'b0;
`endif

  assign dbg_state = state_q;

endmodule

// File: tb/tb_deal_sequencer.sv
// Bench for deal_sequencer: a card-register model feeds scores back, table rounds plus
// hand-written reset and auto-restart sequences are checked through an expected queue.
module tb_deal_sequencer;

  logic       slow_clock = 1'b0;
  logic       resetb = 1'b0;
  logic [3:0] pscore, dscore, pcard3;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light, new_round;
  logic [3:0] dbg_state;

  deal_sequencer #(.HOLD_CYCLES(3)) dut (
    .slow_clock       (slow_clock),
    .resetb           (resetb),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light),
    .new_round        (new_round),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 slow_clock = ~slow_clock;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- card datapath model ----------------
  int   deal_cards[6];
  logic [3:0] card_q[6];
  logic [5:0] strobes;
  assign strobes = {load_dcard3, load_pcard3, load_dcard2, load_pcard2, load_dcard1, load_pcard1};

  always @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < 6; i++) card_q[i] <= 4'd0;
    end else if (new_round) begin
      for (int i = 0; i < 6; i++) card_q[i] <= 4'd0;
    end else begin
      for (int i = 0; i < 6; i++)
        if (strobes[i]) card_q[i] <= 4'(deal_cards[i]);
    end
  end

  function automatic int card_val(input logic [3:0] c);
    return (c >= 4'd10) ? 0 : int'(c);
  endfunction

  always_comb begin
    pscore = 4'((card_val(card_q[0]) + card_val(card_q[2]) + card_val(card_q[4])) % 10);
    dscore = 4'((card_val(card_q[1]) + card_val(card_q[3]) + card_val(card_q[5])) % 10);
    pcard3 = card_q[4];
  end

  // {new_round, player, dealer, D3, P3, D2, P2, D1, P1}
  logic [8:0] dut_vec;
  assign dut_vec = {new_round, player_win_light, dealer_win_light, strobes};

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: act=%b req=%b at %0t", name, act, req, $time);
    end
  endtask

  task automatic drain(input string name);
    logic [8:0] e;
    while (exp_q.size() > 0) begin
      @(posedge slow_clock);
      #1;
      e = exp_q.pop_front();
      check(name, dut_vec, e);
    end
  endtask

  task automatic apply_reset();
    @(negedge slow_clock);
    resetb = 1'b0;
    @(negedge slow_clock);
    check("reset_state", dut_vec, 9'h000);
    resetb = 1'b1;
  endtask

  // ---------------- vector table ----------------
  // path codes: 1..6 = strobe P1,D1,P2,D2,P3,D3; 0 = no strobe (EVAL/BDEC); 7 = DONE
  typedef struct {
    string name;
    int    cards[6];
    int    path[10];
    int    plen;
    logic  pw;
    logic  dw;
  } round_t;

  round_t tbl[10];

  function automatic logic [8:0] code_vec(input int code, input logic pw, input logic dw);
    logic [8:0] v;
    v = 9'h000;
    if (code >= 1 && code <= 6) v[code-1] = 1'b1;
    if (code == 7) begin v[7] = pw; v[6] = dw; end
    return v;
  endfunction

  task automatic run_round(input round_t r);
    for (int i = 0; i < 6; i++) deal_cards[i] = r.cards[i];
    for (int k = 0; k < r.plen; k++) exp_q.push_back(code_vec(r.path[k], r.pw, r.dw));
    // DONE must hold with unchanged lights
    exp_q.push_back(code_vec(7, r.pw, r.dw));
    exp_q.push_back(code_vec(7, r.pw, r.dw));
    apply_reset();
    drain(r.name);
  endtask

  initial begin
    //          name        P1 D1 P2 D2 P3 D3     path                               len  pw    dw
    tbl[0] = '{"natural",   '{4, 2, 5, 3, 0, 0},  '{1,2,3,4,0,7,0,0,0,0}, 6, 1'b1, 1'b0};
    tbl[1] = '{"p_b_draw",  '{1, 2, 2, 2, 6, 3},  '{1,2,3,4,0,5,0,6,7,0}, 9, 1'b1, 1'b0};
    tbl[2] = '{"b_stand_8", '{1, 1, 1, 2, 8, 0},  '{1,2,3,4,0,5,0,7,0,0}, 8, 1'b0, 1'b1};
    tbl[3] = '{"face_p3",   '{2, 3, 2, 3,13, 0},  '{1,2,3,4,0,5,0,7,0,0}, 8, 1'b0, 1'b1};
    tbl[4] = '{"p_stand7",  '{3, 2, 4, 3, 0,13},  '{1,2,3,4,0,6,7,0,0,0}, 7, 1'b1, 1'b0};
    tbl[5] = '{"tie_6",     '{3, 1, 3, 5, 0, 0},  '{1,2,3,4,0,7,0,0,0,0}, 6, 1'b1, 1'b1};
    tbl[6] = '{"d5_v3",     '{1, 2, 1, 3, 3, 0},  '{1,2,3,4,0,5,0,7,0,0}, 8, 1'b1, 1'b1};
    tbl[7] = '{"d2_v8",     '{1, 1, 1, 1, 8, 5},  '{1,2,3,4,0,5,0,6,7,0}, 9, 1'b0, 1'b1};
    tbl[8] = '{"d_natural", '{1, 4, 1, 4, 0, 0},  '{1,2,3,4,0,7,0,0,0,0}, 6, 1'b0, 1'b1};
    tbl[9] = '{"d4_ace",    '{2, 2, 2, 2, 1, 0},  '{1,2,3,4,0,5,0,7,0,0}, 8, 1'b1, 1'b0};

    for (int i = 0; i < 6; i++) deal_cards[i] = 0;
    resetb = 1'b0;
    repeat (2) @(posedge slow_clock);

    for (int t = 0; t < 10; t++) run_round(tbl[t]);

    // Re-run in shuffled order so each round starts from a prior DONE state.
    for (int n = 0; n < 4; n++) run_round(tbl[$urandom_range(9, 0)]);

    // Reset mid-round while in P3: outputs clear before any clock edge.
    for (int i = 0; i < 6; i++) deal_cards[i] = tbl[1].cards[i];
    for (int k = 0; k < 6; k++) exp_q.push_back(code_vec(tbl[1].path[k], 1'b0, 1'b0));
    apply_reset();
    drain("pre_abort");
    #2;
    resetb = 1'b0;
    #1;
    check("async_reset", dut_vec, 9'h000);
    @(negedge slow_clock);
    check("held_reset", dut_vec, 9'h000);
    resetb = 1'b1;
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h002);
    drain("post_abort");

`ifdef AUTO_RESTART_EN
    // Natural round, DONE for 3 cycles, one CLR cycle, then P1 again.
    for (int i = 0; i < 6; i++) deal_cards[i] = tbl[0].cards[i];
    for (int k = 0; k < 6; k++) exp_q.push_back(code_vec(tbl[0].path[k], 1'b1, 1'b0));
    exp_q.push_back(code_vec(7, 1'b1, 1'b0));
    exp_q.push_back(code_vec(7, 1'b1, 1'b0));
    exp_q.push_back(9'h100);
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h002);
    apply_reset();
    drain("auto_restart");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
